// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control path: states, opcodes,
// ALUOp and mux selects, plus the Moore output table for the control FSM.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_JAL      = 4'd10,
    S_BEQ      = 4'd11,
    S_ERR      = 4'd12
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // One-hot instruction class bit positions.
  localparam int CLS_LOAD   = 0;
  localparam int CLS_STORE  = 1;
  localparam int CLS_RTYPE  = 2;
  localparam int CLS_ITYPE  = 3;
  localparam int CLS_JAL    = 4;
  localparam int CLS_BRANCH = 5;
  localparam int CLS_W      = 6;

  typedef logic [CLS_W-1:0] op_class_t;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1; c.pc_update = 1'b1; c.result_src = RES_ALURESULT;
        c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR; c.alu_op = ALUOP_ADD;
      end
      S_DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
      S_MEMADR:   begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; end
      S_MEMREAD:  begin c.result_src = RES_ALUOUT; c.adr_src = 1'b1; end
      S_MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; c.instr_done = 1'b1; end
      S_EXECR: begin
        c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_op = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_FUNCT;
      end
      S_ALUWB:    begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.pc_update = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_op = ALUOP_SUB;
        c.branch = 1'b1; c.instr_done = 1'b1;
      end
      S_ERR:      begin c.illegal_op = 1'b1; c.instr_done = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/main_fsm_op_classifier.sv
// Combinational opcode classifier: one-hot instruction class plus legality flag.
module op_classifier
  import main_fsm_pkg::*;
(
  input  logic [6:0] op,
  output op_class_t  op_class,
  output logic       is_legal
);

  always_comb begin
    // NOTE: default every output before the case so no path leaves it unassigned (no latch).
    op_class = '0;
    case (op)
      OP_LOAD:   op_class[CLS_LOAD]   = 1'b1;
      OP_STORE:  op_class[CLS_STORE]  = 1'b1;
      OP_RTYPE:  op_class[CLS_RTYPE]  = 1'b1;
      OP_ITYPE:  op_class[CLS_ITYPE]  = 1'b1;
      OP_JAL:    op_class[CLS_JAL]    = 1'b1;
      OP_BRANCH: op_class[CLS_BRANCH] = 1'b1;
      default:   op_class = '0;
    endcase
    is_legal = |op_class;
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RV32I control FSM (Moore, registered outputs).
// Optional MAIN_FSM_MEM_WAIT_EN adds mem_ready and stalls memory states.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
`ifdef MAIN_FSM_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_update,
  output logic       branch,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state_o
);

  state_e    state_q, state_d;
  ctrl_t     ctrl_q;
  op_class_t op_class;
  logic      is_legal;
  logic      mem_go;

  op_classifier u_classifier (
    .op       (op),
    .op_class (op_class),
    .is_legal (is_legal)
  );

`ifdef MAIN_FSM_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    state_d = mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!is_legal)                                     state_d = STRICT_DECODE ? S_ERR : S_FETCH;
        else if (op_class[CLS_LOAD] || op_class[CLS_STORE]) state_d = S_MEMADR;
        else if (op_class[CLS_RTYPE])                      state_d = S_EXECR;
        else if (op_class[CLS_ITYPE])                      state_d = S_EXECI;
        else if (op_class[CLS_JAL])                        state_d = S_JAL;
        else                                               state_d = S_BEQ;
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_go ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_go ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_ERR:      state_d = S_FETCH;
      default:    state_d = S_IDLE;  // unreachable encodings recover
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
    end
  end

`ifdef MAIN_FSM_MEM_WAIT_EN
  assign ir_write  = ctrl_q.ir_write  & mem_ready;
  assign pc_update = ctrl_q.pc_update & ((state_q != S_FETCH) | mem_ready);
  assign mem_write = ctrl_q.mem_write & mem_ready;
`else
  assign ir_write  = ctrl_q.ir_write;
  assign pc_update = ctrl_q.pc_update;
  assign mem_write = ctrl_q.mem_write;
`endif

  assign branch     = ctrl_q.branch;
  assign adr_src    = ctrl_q.adr_src;
  assign result_src = ctrl_q.result_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign reg_write  = ctrl_q.reg_write;
  assign illegal_op = ctrl_q.illegal_op;
  assign instr_done = ctrl_q.instr_done;
  assign state_o    = state_q;

endmodule
